// File: rtl/thermostat_ctrl.sv
// Single-zone heating/cooling controller with hysteresis thresholds,
// minimum-dwell anti-short-cycle timer, operating mode select,
// sample-valid qualification and sensor-fault override.
module thermostat_ctrl #(
    parameter int TEMP_W     = 5,
    parameter int HEAT_ON    = 18,
    parameter int HEAT_OFF   = 20,
    parameter int COOL_ON    = 22,
    parameter int COOL_OFF   = 20,
    parameter int MIN_DWELL  = 4,
    parameter int FAULT_CODE = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic              temp_valid,
    input  logic [1:0]        mode,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              fault,
    output logic              dwell_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEATING = 2'd1,
        ST_COOLING = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_HEAT_ONLY = 2'd1,
        MODE_COOL_ONLY = 2'd2,
        MODE_AUTO      = 2'd3
    } mode_t;

    // A zero dwell still needs a one-bit counter so the vector is legal.
    localparam int CNT_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

    localparam logic [TEMP_W-1:0] HEAT_ON_T    = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] HEAT_OFF_T   = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] COOL_ON_T    = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] COOL_OFF_T   = TEMP_W'(COOL_OFF);
    localparam logic [TEMP_W-1:0] FAULT_CODE_T = TEMP_W'(FAULT_CODE);
    localparam logic [CNT_W-1:0]  DWELL_MAX    = CNT_W'(MIN_DWELL);

    // Threshold ordering must leave a hysteresis band and keep the fault code out of range.
    if (!(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON &&
          COOL_ON < FAULT_CODE && FAULT_CODE < 2**TEMP_W)) begin : g_param_check
        $error("thermostat_ctrl: illegal threshold/fault parameters");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] dwell_cnt;
    logic             fault_sample;
    logic             force_idle;
    mode_t            mode_e;

    assign mode_e       = mode_t'(mode);
    assign fault_sample = temp_valid && (temp == FAULT_CODE_T);
    assign dwell_done   = (dwell_cnt == DWELL_MAX);
    assign state        = state_q;

    // Conditions that drop to IDLE at once, bypassing the dwell timer.
    always_comb begin
        force_idle = 1'b0;
        if (fault || fault_sample)
            force_idle = 1'b1;
        else if (mode_e == MODE_OFF)
            force_idle = 1'b1;
        else if (state_q == ST_COOLING && mode_e == MODE_HEAT_ONLY)
            force_idle = 1'b1;
        else if (state_q == ST_HEATING && mode_e == MODE_COOL_ONLY)
            force_idle = 1'b1;
    end

    // Next-state decision: forced exits first, then dwell-qualified temperature moves.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        state_d = state_q;
        if (force_idle) begin
            state_d = ST_IDLE;
        end else if (temp_valid && dwell_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (temp <= HEAT_ON_T &&
                        (mode_e == MODE_HEAT_ONLY || mode_e == MODE_AUTO))
                        state_d = ST_HEATING;
                    else if (temp >= COOL_ON_T &&
                             (mode_e == MODE_COOL_ONLY || mode_e == MODE_AUTO))
                        state_d = ST_COOLING;
                end
                ST_HEATING: begin
                    if (temp >= HEAT_OFF_T)
                        state_d = ST_IDLE;
                end
                ST_COOLING: begin
                    if (temp <= COOL_OFF_T)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register, registered drives, fault flag and saturating dwell counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            heating   <= 1'b0;
            cooling   <= 1'b0;
            fault     <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            heating <= (state_d == ST_HEATING);
            cooling <= (state_d == ST_COOLING);
            if (temp_valid)
                fault <= (temp == FAULT_CODE_T);
            if (state_d != state_q)
                dwell_cnt <= '0;
            else if (dwell_cnt != DWELL_MAX)
                dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

endmodule
